// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
// Holds the loader FSM state encoding, the default program length limit and
// the byte index of the last byte within an instruction word.
package loader_pkg;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StCsum,
    StDone,
    StError
  } loader_state_e;

  localparam int unsigned DefaultMaxWords = 1024;

  // Byte counter value at which a word is complete (bytes 0..3).
  localparam logic [1:0] LastByteIdx = 2'd3;

endpackage

// File: rtl/word_assembler.sv
// Collects four big-endian bytes into one 32-bit instruction word.
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset
//   byte_en_i    - a data byte is accepted this cycle
//   byte_i       - the data byte
//   cnt_o        - index (0..3) of the next byte within the current word
//   word_valid_o - one-cycle pulse, the cycle after the 4th byte is accepted
//   word_o       - the assembled word, first byte in [31:24]
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  cnt_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (byte_en_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
      if (cnt_q == LastByteIdx) begin
        word_d  = {shift_q, byte_i};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: parses a host byte stream
// (LEN_HI, LEN_LO, 4*N data bytes, CSUM) and writes the words to
// instruction memory while holding the CPU in reset.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   byte_valid_i   - host offers byte_data_i
//   byte_data_i    - host byte stream
//   byte_ready_o   - loader accepts a byte
//   imem_we_o      - one-cycle instruction memory write strobe
//   imem_addr_o    - word-aligned byte address of the write
//   imem_wdata_o   - instruction word of the write
//   cpu_hold_o     - CPU held in reset while high
//   done_o         - load completed with a good checksum
//   error_o        - load aborted
module inst_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = DefaultMaxWords
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        error_o
);

  loader_state_e state_q, state_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [31:0]   addr_q, addr_d;

  logic          accept;
  logic          data_en;
  logic [15:0]   len_rx;
  logic [1:0]    asm_cnt;
  logic          asm_valid;
  logic [31:0]   asm_word;

  assign accept  = byte_valid_i & byte_ready_o;
  assign data_en = accept & (state_q == StData);
  assign len_rx  = {len_hi_q, byte_data_i};

  word_assembler u_word_assembler (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_en_i    (data_en),
    .byte_i       (byte_data_i),
    .cnt_o        (asm_cnt),
    .word_valid_o (asm_valid),
    .word_o       (asm_word)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    unique case (state_q)
      StLenHi: begin
        if (accept) begin
          len_hi_d = byte_data_i;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_rx;
          if (len_rx == 16'd0) begin
            state_d = StCsum;
          end else if (32'(len_rx) > 32'(MAX_WORDS)) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ byte_data_i;
          if (asm_cnt == LastByteIdx) begin
            // Address is registered alongside the assembled word so both
            // appear in the write cycle.
            addr_d     = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == len_q - 16'd1) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (byte_data_i == csum_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        state_d = state_q;
      end
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StLenHi;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
    end
  end

  // Outputs are forced to their idle values while reset is asserted so the
  // reset cycle itself shows no ready, no write and a held CPU.
  always_comb begin
    byte_ready_o = 1'b0;
    cpu_hold_o   = 1'b1;
    done_o       = 1'b0;
    error_o      = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        StLenHi, StLenLo, StData, StCsum: byte_ready_o = 1'b1;
        StDone: begin
          done_o     = 1'b1;
          cpu_hold_o = 1'b0;
        end
        StError: error_o = 1'b1;
        default: error_o = 1'b1;
      endcase
    end
  end

  assign imem_we_o    = asm_valid & ~rst_i;
  assign imem_addr_o  = rst_i ? 32'd0 : addr_q;
  assign imem_wdata_o = rst_i ? 32'd0 : asm_word;

endmodule
